// File: rtl/game_score_ctrl.sv
// game_score_ctrl: player login tracking, two-digit BCD game score and timed
// SUBMIT / SHOW_TOP command generation for the downstream leaderboard stage.
//
// Optional feature macro: PENALTY_EN (miss decrements the score, floor 00).
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   login/login_id/login_guest  latch player identity
//   logout, game_start, hit, miss, game_over, show_top  one-cycle pulses
//   controlSig         000 NOP, 001 SUBMIT, 010 SHOW_TOP
//   isGuest, intIDin   registered player identity
//   scoreOnes/Tens     BCD score digits
//   game_active, busy  status flags
module game_score_ctrl #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned MAX_SCORE   = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       login,
  input  logic [2:0] login_id,
  input  logic       login_guest,
  input  logic       logout,
  input  logic       game_start,
  input  logic       hit,
  input  logic       miss,
  input  logic       game_over,
  input  logic       show_top,
  output logic [2:0] controlSig,
  output logic       isGuest,
  output logic [2:0] intIDin,
  output logic [3:0] scoreOnes,
  output logic [3:0] scoreTens,
  output logic       game_active,
  output logic       busy
);

  localparam int unsigned CntW  = 4;
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES);
  localparam logic [3:0] MaxTens = 4'(MAX_SCORE / 10);
  localparam logic [3:0] MaxOnes = 4'(MAX_SCORE % 10);

  localparam logic [2:0] CmdNop     = 3'b000;
  localparam logic [2:0] CmdSubmit  = 3'b001;
  localparam logic [2:0] CmdShowTop = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE, S_READY, S_PLAY, S_SUBMIT, S_SHOWTOP
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      id_q, id_d;
  logic            guest_q, guest_d;
  logic [3:0]      ones_q, ones_d, tens_q, tens_d;
  logic            ret_ready_q, ret_ready_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic            active_q, active_d;
  logic            busy_q, busy_d;

  logic [3:0] inc_ones, inc_tens;
  logic       at_max;

  // Saturating BCD increment
  always_comb begin
    at_max   = (tens_q > MaxTens) || ((tens_q == MaxTens) && (ones_q >= MaxOnes));
    inc_ones = ones_q;
    inc_tens = tens_q;
    if (!at_max) begin
      if (ones_q == 4'd9) begin
        inc_ones = 4'd0;
        inc_tens = tens_q + 4'd1;
      end else begin
        inc_ones = ones_q + 4'd1;
      end
    end
  end

`ifdef PENALTY_EN
  logic [3:0] dec_ones, dec_tens;

  // BCD decrement with floor at 00
  always_comb begin
    dec_ones = ones_q;
    dec_tens = tens_q;
    if (ones_q != 4'd0) begin
      dec_ones = ones_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = tens_q - 4'd1;
    end
  end
`else
  logic unused_miss;
  assign unused_miss = miss;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    guest_d     = guest_q;
    ones_d      = ones_q;
    tens_d      = tens_q;
    ret_ready_d = ret_ready_q;

    case (state_q)
      S_IDLE: begin
        if (login) begin
          id_d    = login_id;
          guest_d = login_guest;
          state_d = S_READY;
        end else if (show_top) begin
          cnt_d       = HoldLoad;
          ret_ready_d = 1'b0;
          state_d     = S_SHOWTOP;
        end
      end
      S_READY: begin
        if (game_start) begin
          ones_d  = 4'd0;
          tens_d  = 4'd0;
          state_d = S_PLAY;
        end else if (logout) begin
          id_d    = 3'd0;
          guest_d = 1'b0;
          state_d = S_IDLE;
        end else if (show_top) begin
          cnt_d       = HoldLoad;
          ret_ready_d = 1'b1;
          state_d     = S_SHOWTOP;
        end else if (login) begin
          id_d    = login_id;
          guest_d = login_guest;
        end
      end
      S_PLAY: begin
`ifdef PENALTY_EN
        if (hit && !miss) begin
          ones_d = inc_ones;
          tens_d = inc_tens;
        end else if (miss && !hit) begin
          ones_d = dec_ones;
          tens_d = dec_tens;
        end
`else
        if (hit) begin
          ones_d = inc_ones;
          tens_d = inc_tens;
        end
`endif
        // Score and state update on the same edge, so a coincident hit is committed
        if (game_over) begin
          cnt_d   = HoldLoad;
          state_d = S_SUBMIT;
        end
      end
      S_SUBMIT: begin
        if (cnt_q <= CntW'(1)) begin
          cnt_d   = '0;
          state_d = S_READY;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      S_SHOWTOP: begin
        if (cnt_q <= CntW'(1)) begin
          cnt_d   = '0;
          state_d = ret_ready_q ? S_READY : S_IDLE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs follow the next state so they register alongside it
    ctrl_d   = CmdNop;
    busy_d   = 1'b0;
    active_d = (state_d == S_PLAY);
    if (state_d == S_SUBMIT) begin
      ctrl_d = CmdSubmit;
      busy_d = 1'b1;
    end else if (state_d == S_SHOWTOP) begin
      ctrl_d = CmdShowTop;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      id_q        <= 3'd0;
      guest_q     <= 1'b0;
      ones_q      <= 4'd0;
      tens_q      <= 4'd0;
      ret_ready_q <= 1'b0;
      ctrl_q      <= CmdNop;
      active_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      guest_q     <= guest_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      ret_ready_q <= ret_ready_d;
      ctrl_q      <= ctrl_d;
      active_q    <= active_d;
      busy_q      <= busy_d;
    end
  end

  assign controlSig  = ctrl_q;
  assign isGuest     = guest_q;
  assign intIDin     = id_q;
  assign scoreOnes   = ones_q;
  assign scoreTens   = tens_q;
  assign game_active = active_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Directed testbench for game_score_ctrl (default parameters).
module tb_game_score_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       login, login_guest, logout, game_start, hit, miss, game_over, show_top;
  logic [2:0] login_id;
  logic [2:0] controlSig;
  logic       isGuest;
  logic [2:0] intIDin;
  logic [3:0] scoreOnes, scoreTens;
  logic       game_active, busy;

  int n_assert = 0;
  int n_fail   = 0;

  game_score_ctrl dut (
    .clk(clk), .rst(rst),
    .login(login), .login_id(login_id), .login_guest(login_guest),
    .logout(logout), .game_start(game_start), .hit(hit), .miss(miss),
    .game_over(game_over), .show_top(show_top),
    .controlSig(controlSig), .isGuest(isGuest), .intIDin(intIDin),
    .scoreOnes(scoreOnes), .scoreTens(scoreTens),
    .game_active(game_active), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_score(input string tag, input int t, input int o);
    chk({tag, "_tens"}, 32'(scoreTens), 32'(t));
    chk({tag, "_ones"}, 32'(scoreOnes), 32'(o));
  endtask

  task automatic hits(input int n);
    hit = 1'b1;
    repeat (n) tick();
    hit = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    login = 0; login_id = 0; login_guest = 0; logout = 0; game_start = 0;
    hit = 0; miss = 0; game_over = 0; show_top = 0;
    tick(); tick();
    chk("rst_ctrl", 32'(controlSig), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_active", 32'(game_active), 0);
    chk("rst_id", 32'(intIDin), 0);
    chk("rst_guest", 32'(isGuest), 0);
    chk_score("rst", 0, 0);
    rst = 1'b1;
    tick();

    // Login id 5, play 23 hits, submit
    login = 1; login_id = 3'd5; login_guest = 0;
    tick();
    login = 0;
    chk("login_id", 32'(intIDin), 5);
    chk("login_guest", 32'(isGuest), 0);
    chk("ready_active", 32'(game_active), 0);
    game_start = 1; tick(); game_start = 0;
    chk("start_active", 32'(game_active), 1);
    chk_score("start", 0, 0);
    hits(23);
    chk_score("h23", 2, 3);
    game_over = 1; tick(); game_over = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sub_ctrl%0d", i), 32'(controlSig), 1);
      chk($sformatf("sub_busy%0d", i), 32'(busy), 1);
      chk($sformatf("sub_id%0d", i), 32'(intIDin), 5);
      chk_score($sformatf("sub%0d", i), 2, 3);
      hit = (i == 1);
      tick();
      hit = 0;
    end
    chk("post_sub_ctrl", 32'(controlSig), 0);
    chk("post_sub_busy", 32'(busy), 0);
    chk("post_sub_active", 32'(game_active), 0);
    chk_score("post_sub", 2, 3);

    // Carry and hit+game_over coincidence
    game_start = 1; tick(); game_start = 0;
    chk_score("restart", 0, 0);
    hits(9);
    chk_score("h9", 0, 9);
    hits(1);
    chk_score("carry", 1, 0);
    hits(31);
    chk_score("h41", 4, 1);
`ifndef PENALTY_EN
    miss = 1; tick(); miss = 0;
    chk_score("miss_ignored", 4, 1);
`endif
    hit = 1; game_over = 1; tick(); hit = 0; game_over = 0;
    chk("hg_ctrl", 32'(controlSig), 1);
    chk_score("hg", 4, 2);
    tick(); tick(); tick();
    chk("hg_last_ctrl", 32'(controlSig), 1);
    tick();
    chk("hg_done_ctrl", 32'(controlSig), 0);

    // Saturation
    game_start = 1; tick(); game_start = 0;
    hits(105);
    chk_score("sat", 9, 9);
    game_over = 1; tick(); game_over = 0;
    repeat (4) tick();
    chk("sat_done_ctrl", 32'(controlSig), 0);

    // Logout then SHOWTOP from IDLE with an ignored login
    logout = 1; tick(); logout = 0;
    chk("logout_id", 32'(intIDin), 0);
    show_top = 1; tick(); show_top = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("st_ctrl%0d", i), 32'(controlSig), 2);
      chk($sformatf("st_busy%0d", i), 32'(busy), 1);
      login = (i == 1); login_id = 3'd7; login_guest = 1;
      tick();
      login = 0;
    end
    chk("st_done_ctrl", 32'(controlSig), 0);
    chk("st_id", 32'(intIDin), 0);
    chk("st_guest", 32'(isGuest), 0);
    game_start = 1; tick(); game_start = 0;
    chk("idle_start_ignored", 32'(game_active), 0);

    // Guest login, SHOWTOP from READY returns to READY
    login = 1; login_id = 3'd3; login_guest = 1; tick(); login = 0;
    chk("guest_id", 32'(intIDin), 3);
    chk("guest_flag", 32'(isGuest), 1);
    show_top = 1; tick(); show_top = 0;
    chk("st2_ctrl", 32'(controlSig), 2);
    repeat (4) tick();
    chk("st2_done_ctrl", 32'(controlSig), 0);
    game_start = 1; tick(); game_start = 0;
    chk("st2_ready_start", 32'(game_active), 1);

`ifdef PENALTY_EN
    hits(10);
    chk_score("p10", 1, 0);
    miss = 1; tick(); miss = 0;
    chk_score("p_borrow", 0, 9);
    hit = 1; miss = 1; tick(); hit = 0; miss = 0;
    chk_score("p_cancel", 0, 9);
    miss = 1; repeat (9) tick(); miss = 0;
    chk_score("p_zero", 0, 0);
    miss = 1; tick(); miss = 0;
    chk_score("p_floor", 0, 0);
    hits(2);
`else
    hits(2);
`endif
    // Reset during 2nd SUBMIT cycle
    game_over = 1; tick(); game_over = 0;
    chk("rs_ctrl1", 32'(controlSig), 1);
    chk_score("rs_sub", 0, 2);
    tick();
    chk("rs_ctrl2", 32'(controlSig), 1);
    #2 rst = 1'b0;
    #1;
    chk("rs_async_ctrl", 32'(controlSig), 0);
    chk("rs_async_busy", 32'(busy), 0);
    chk("rs_async_id", 32'(intIDin), 0);
    chk("rs_async_guest", 32'(isGuest), 0);
    chk_score("rs_async", 0, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("rs_rel_ctrl", 32'(controlSig), 0);
    game_start = 1; tick(); game_start = 0;
    chk("rs_idle_start", 32'(game_active), 0);
    login = 1; login_id = 3'd6; login_guest = 0; tick(); login = 0;
    chk("rs_login", 32'(intIDin), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
